// File: rtl/spmv_mem_sched_if.sv
// DCP memory port bundle: request channel out, response channel back.
// The scheduler takes the master side, the NoC adapter the slave side.
interface spmv_mem_sched_if #(
    parameter int TID_W  = 6,
    parameter int DATA_W = 512
);
    logic              mem_req_val;
    logic              mem_req_rdy;
    logic [TID_W-1:0]  mem_req_transid;
    logic [39:0]       mem_req_addr;
    logic              mem_resp_val;
    logic [TID_W-1:0]  mem_resp_transid;
    logic [DATA_W-1:0] mem_resp_data;

    modport master (
        output mem_req_val,
        output mem_req_transid,
        output mem_req_addr,
        input  mem_req_rdy,
        input  mem_resp_val,
        input  mem_resp_transid,
        input  mem_resp_data
    );

    modport slave (
        input  mem_req_val,
        input  mem_req_transid,
        input  mem_req_addr,
        output mem_req_rdy,
        output mem_resp_val,
        output mem_resp_transid,
        output mem_resp_data
    );
endinterface

// File: rtl/spmv_mem_sched.sv
// Shares one DCP request/response port among SpMV fetch engines:
// round-robin grant, transid pool, response routing by owner/tag.
module spmv_mem_sched #(
    parameter int NUM_REQ = 3,
    parameter int TID_W   = 6,
    parameter int TAG_W   = 4,
    parameter int MAX_OUT = 64,
    parameter int DATA_W  = 512
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     spmv_init,
    input  logic [NUM_REQ-1:0]       req_val,
    output logic [NUM_REQ-1:0]       req_rdy,
    input  logic [NUM_REQ*40-1:0]    req_addr,
    input  logic [NUM_REQ*TAG_W-1:0] req_tag,
    spmv_mem_sched_if.master         mem,
    output logic [NUM_REQ-1:0]       resp_val,
    output logic [TAG_W-1:0]         resp_tag,
    output logic [DATA_W-1:0]        resp_data,
    output logic [TID_W:0]           outstanding,
    output logic                     idle,
    output logic                     err_spurious
);
    localparam int NID = 1 << TID_W;
    localparam int GW  = $clog2(NUM_REQ);

    logic [NID-1:0]   busy;
    logic [GW-1:0]    owner [NID];
    logic [TAG_W-1:0] tag_q [NID];

    logic [GW-1:0]    rr_ptr;
    logic [GW-1:0]    rr_g;
    logic [GW-1:0]    rr_idx;
    logic [GW-1:0]    gnt;
    logic [GW-1:0]    lock_g;
    logic [TID_W-1:0] free_id;
    logic [TID_W-1:0] lock_id;
    logic [TID_W-1:0] tid;
    logic [TID_W-1:0] rid;
    logic [TAG_W-1:0] gtag;
    logic             rr_any;
    logic             free_any;
    logic             lock_vld;
    logic             gnt_vld;
    logic             id_avail;
    logic             hs;
    logic             hit;

    assign rid = mem.mem_resp_transid;
    assign hit = mem.mem_resp_val && busy[rid];

    // Lowest-index free ID from the pre-edge busy vector
    always_comb begin
        free_id  = '0;
        free_any = 1'b0;
        for (int i = NID - 1; i >= 0; i--) begin
            if (!busy[TID_W'(i)]) begin
                free_id  = TID_W'(i);
                free_any = 1'b1;
            end
        end
    end

    // rr_ptr holds the first requester to consider next
    always_comb begin
        rr_g   = '0;
        rr_any = 1'b0;
        rr_idx = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            rr_idx = GW'((int'(rr_ptr) + i) % NUM_REQ);
            if (req_val[rr_idx]) begin
                rr_g   = rr_idx;
                rr_any = 1'b1;
            end
        end
    end

    assign gnt      = lock_vld ? lock_g : rr_g;
    assign gnt_vld  = lock_vld | rr_any;
    assign tid      = lock_vld ? lock_id : free_id;
    assign id_avail = lock_vld |
                      (free_any && (outstanding < (TID_W+1)'(MAX_OUT)));

    assign mem.mem_req_val     = gnt_vld && id_avail && !spmv_init;
    assign mem.mem_req_transid = tid;
    assign hs = mem.mem_req_val && mem.mem_req_rdy;

    always_comb begin
        mem.mem_req_addr = '0;
        gtag             = '0;
        req_rdy          = '0;
        for (int r = 0; r < NUM_REQ; r++) begin
            if (gnt == GW'(r)) begin
                mem.mem_req_addr = req_addr[r*40 +: 40];
                gtag             = req_tag[r*TAG_W +: TAG_W];
                req_rdy[r]       = hs;
            end
        end
    end

    assign idle = (outstanding == '0) && !(|req_val);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NID; i++) begin
                owner[i] <= '0;
                tag_q[i] <= '0;
            end
        end else if (spmv_init) begin
            for (int i = 0; i < NID; i++) begin
                owner[i] <= '0;
                tag_q[i] <= '0;
            end
        end else if (hs) begin
            owner[tid] <= gnt;
            tag_q[tid] <= gtag;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy         <= '0;
            rr_ptr       <= '0;
            lock_vld     <= 1'b0;
            lock_g       <= '0;
            lock_id      <= '0;
            outstanding  <= '0;
            resp_val     <= '0;
            resp_tag     <= '0;
            resp_data    <= '0;
            err_spurious <= 1'b0;
        end else if (spmv_init) begin
            busy         <= '0;
            rr_ptr       <= '0;
            lock_vld     <= 1'b0;
            lock_g       <= '0;
            lock_id      <= '0;
            outstanding  <= '0;
            resp_val     <= '0;
            resp_tag     <= '0;
            resp_data    <= '0;
            err_spurious <= 1'b0;
        end else begin
            // Free before allocate; the allocated ID was never busy
            if (hit) begin
                busy[rid] <= 1'b0;
            end
            if (hs) begin
                busy[tid] <= 1'b1;
                rr_ptr    <= (gnt == GW'(NUM_REQ - 1)) ? '0 : gnt + 1'b1;
            end
            if (hs) begin
                lock_vld <= 1'b0;
            end else if (mem.mem_req_val) begin
                lock_vld <= 1'b1;
                lock_g   <= gnt;
                lock_id  <= tid;
            end
            outstanding <= outstanding + (TID_W+1)'(hs)
                                       - (TID_W+1)'(hit);
            resp_val <= hit ? (NUM_REQ'(1) << owner[rid]) : '0;
            if (hit) begin
                resp_tag  <= tag_q[rid];
                resp_data <= mem.mem_resp_data;
            end
            err_spurious <= mem.mem_resp_val && !busy[rid];
        end
    end
endmodule

// File: tb/tb_spmv_mem_sched.sv
// Bench for spmv_mem_sched: directed vector table, randomized traffic
// against a pool/queue reference model, async reset mid-transfer.
module tb_spmv_mem_sched;
    localparam int N    = 3;
    localparam int TW   = 6;
    localparam int TAGW = 4;
    localparam int MAXO = 4;
    localparam int DW   = 64;
    localparam int NID  = 1 << TW;

    typedef struct {
        logic [2:0] rv;
        logic       rdy;
        logic       mrv;
        logic [5:0] mid;
        logic       init;
        logic       ev;
        logic [5:0] et;
        logic [2:0] erdy;
        logic [6:0] eout;
        logic [2:0] eresp;
        logic       eerr;
    } vec_t;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            spmv_init = 1'b0;
    logic [N-1:0]    req_val = '0;
    logic [N-1:0]    req_rdy;
    logic [N*40-1:0] req_addr = '0;
    logic [N*TAGW-1:0] req_tag = '0;
    logic [N-1:0]    resp_val;
    logic [TAGW-1:0] resp_tag;
    logic [DW-1:0]   resp_data;
    logic [TW:0]     outstanding;
    logic            idle;
    logic            err_spurious;

    spmv_mem_sched_if #(.TID_W(TW), .DATA_W(DW)) mem ();

    spmv_mem_sched #(
        .NUM_REQ(N), .TID_W(TW), .TAG_W(TAGW),
        .MAX_OUT(MAXO), .DATA_W(DW)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .spmv_init(spmv_init),
        .req_val(req_val),
        .req_rdy(req_rdy),
        .req_addr(req_addr),
        .req_tag(req_tag),
        .mem(mem),
        .resp_val(resp_val),
        .resp_tag(resp_tag),
        .resp_data(resp_data),
        .outstanding(outstanding),
        .idle(idle),
        .err_spurious(err_spurious)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // reference model: ID pool as a busy array, owner/tag per ID
    bit  m_busy [NID];
    int  m_own  [NID];
    int  m_tag  [NID];
    int  m_next;
    bit  m_lock;
    int  m_lg;
    int  m_lid;
    logic [N-1:0]    e_rv;
    logic [TAGW-1:0] e_tag;
    logic [DW-1:0]   e_data;
    logic            e_err;

    int  x_g, x_id, x_out;
    bit  x_gv, x_av, x_val;
    bit  last_hs;
    int  last_g, last_id;

    logic [39:0]     pa [N];
    logic [TAGW-1:0] pt [N];
    bit              pend [N];

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < NID; i++) begin
            m_busy[i] = 1'b0;
            m_own[i]  = 0;
            m_tag[i]  = 0;
        end
        m_next = 0;
        m_lock = 1'b0;
        e_rv   = '0;
        e_tag  = '0;
        e_data = '0;
        e_err  = 1'b0;
    endtask

    task automatic model_comb();
        x_out = 0;
        for (int i = 0; i < NID; i++) if (m_busy[i]) x_out++;
        x_gv = 1'b0;
        x_g  = 0;
        for (int k = 0; k < N; k++) begin
            int r;
            r = (m_next + k) % N;
            if (!x_gv && req_val[r]) begin
                x_gv = 1'b1;
                x_g  = r;
            end
        end
        x_id = 0;
        for (int i = NID - 1; i >= 0; i--) if (!m_busy[i]) x_id = i;
        x_av = (x_out < MAXO) && (x_out < NID);
        if (m_lock) begin
            x_gv = 1'b1;
            x_g  = m_lg;
            x_id = m_lid;
            x_av = 1'b1;
        end
        x_val = x_gv && x_av && !spmv_init;
    endtask

    task automatic pack();
        for (int r = 0; r < N; r++) begin
            req_addr[r*40 +: 40]   = pa[r];
            req_tag[r*TAGW +: TAGW] = pt[r];
        end
    endtask

    task automatic cycle(input bit has_v, input vec_t v);
        bit hs, hit;
        int id;
        @(negedge clk);
        model_comb();
        chk("mem_req_val", mem.mem_req_val, x_val);
        if (x_val) begin
            chk("transid", mem.mem_req_transid, x_id);
            chk("addr", mem.mem_req_addr, pa[x_g]);
        end
        chk("req_rdy", req_rdy,
            (x_val && mem.mem_req_rdy) ? (3'b001 << x_g) : 3'b000);
        chk("outstanding", outstanding, x_out);
        chk("idle", idle, (x_out == 0) && (req_val == '0));
        chk("resp_val", resp_val, e_rv);
        chk("resp_tag", resp_tag, e_tag);
        chk("resp_data", resp_data, e_data);
        chk("err_spurious", err_spurious, e_err);
        if (has_v) begin
            chk("vec_val", mem.mem_req_val, v.ev);
            chk("vec_tid", mem.mem_req_transid, v.et);
            chk("vec_rdy", req_rdy, v.erdy);
            chk("vec_out", outstanding, v.eout);
            chk("vec_resp", resp_val, v.eresp);
            chk("vec_err", err_spurious, v.eerr);
        end
        hs  = x_val && mem.mem_req_rdy;
        id  = int'(mem.mem_resp_transid);
        hit = mem.mem_resp_val && m_busy[id];
        last_hs = hs;
        last_g  = x_g;
        if (spmv_init) begin
            model_reset();
        end else begin
            e_rv  = hit ? (3'b001 << m_own[id]) : 3'b000;
            e_err = mem.mem_resp_val && !m_busy[id];
            if (hit) begin
                e_tag     = TAGW'(m_tag[id]);
                e_data    = mem.mem_resp_data;
                m_busy[id] = 1'b0;
            end
            if (hs) begin
                m_busy[x_id] = 1'b1;
                m_own[x_id]  = x_g;
                m_tag[x_id]  = int'(pt[x_g]);
                m_next       = (x_g + 1) % N;
                m_lock       = 1'b0;
                last_id      = x_id;
            end else if (x_val) begin
                m_lock = 1'b1;
                m_lg   = x_g;
                m_lid  = x_id;
            end
        end
        @(posedge clk);
        #1;
    endtask

    function automatic vec_t mk(logic [2:0] rv, logic rdy, logic mrv,
                                logic [5:0] mid, logic init, logic ev,
                                logic [5:0] et, logic [2:0] erdy,
                                logic [6:0] eout, logic [2:0] eresp,
                                logic eerr);
        vec_t v;
        v.rv = rv; v.rdy = rdy; v.mrv = mrv; v.mid = mid;
        v.init = init; v.ev = ev; v.et = et; v.erdy = erdy;
        v.eout = eout; v.eresp = eresp; v.eerr = eerr;
        return v;
    endfunction

    vec_t tv[$];
    vec_t dv;

    initial begin
        // single requester
        tv.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        tv.push_back(mk(1, 1, 0, 0, 0, 1, 0, 1, 0, 0, 0));
        tv.push_back(mk(0, 0, 1, 0, 0, 0, 1, 0, 1, 0, 0));
        tv.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0));
        // round robin, then pool exhaustion and same-edge reuse
        tv.push_back(mk(0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0));
        tv.push_back(mk(7, 1, 0, 0, 0, 1, 0, 1, 0, 0, 0));
        tv.push_back(mk(7, 1, 0, 0, 0, 1, 1, 2, 1, 0, 0));
        tv.push_back(mk(7, 1, 0, 0, 0, 1, 2, 4, 2, 0, 0));
        tv.push_back(mk(7, 1, 0, 0, 0, 1, 3, 1, 3, 0, 0));
        tv.push_back(mk(7, 1, 0, 0, 0, 0, 4, 0, 4, 0, 0));
        tv.push_back(mk(7, 1, 1, 2, 0, 0, 4, 0, 4, 0, 0));
        tv.push_back(mk(7, 1, 0, 0, 0, 1, 2, 2, 3, 4, 0));
        tv.push_back(mk(0, 1, 0, 0, 0, 0, 4, 0, 4, 0, 0));
        // out-of-order returns
        tv.push_back(mk(0, 0, 0, 0, 1, 0, 4, 0, 4, 0, 0));
        tv.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        tv.push_back(mk(1, 1, 0, 0, 0, 1, 0, 1, 0, 0, 0));
        tv.push_back(mk(2, 1, 0, 0, 0, 1, 1, 2, 1, 0, 0));
        tv.push_back(mk(4, 1, 0, 0, 0, 1, 2, 4, 2, 0, 0));
        tv.push_back(mk(0, 0, 1, 2, 0, 0, 3, 0, 3, 0, 0));
        tv.push_back(mk(0, 0, 1, 0, 0, 0, 2, 0, 2, 4, 0));
        tv.push_back(mk(0, 0, 1, 1, 0, 0, 0, 0, 1, 1, 0));
        tv.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 2, 0));
        // stall lock on r1 while r0 also requests
        tv.push_back(mk(2, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0));
        for (int i = 0; i < 4; i++)
            tv.push_back(mk(3, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0));
        tv.push_back(mk(3, 1, 0, 0, 0, 1, 0, 2, 0, 0, 0));
        tv.push_back(mk(1, 1, 0, 0, 0, 1, 1, 1, 1, 0, 0));
        tv.push_back(mk(0, 0, 0, 0, 0, 0, 2, 0, 2, 0, 0));
        // spurious response, then flush with 3 outstanding
        tv.push_back(mk(0, 0, 1, 9, 0, 0, 2, 0, 2, 0, 0));
        tv.push_back(mk(0, 0, 0, 0, 0, 0, 2, 0, 2, 0, 1));
        tv.push_back(mk(4, 1, 0, 0, 0, 1, 2, 4, 2, 0, 0));
        tv.push_back(mk(0, 0, 0, 0, 1, 0, 3, 0, 3, 0, 0));
        tv.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        tv.push_back(mk(0, 0, 1, 1, 0, 0, 0, 0, 0, 0, 0));
        tv.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1));

        dv = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        mem.mem_req_rdy      = 1'b0;
        mem.mem_resp_val     = 1'b0;
        mem.mem_resp_transid = '0;
        mem.mem_resp_data    = '0;
        for (int r = 0; r < N; r++) begin
            pa[r]   = 40'h1000 + 40'(r) * 40'h1000;
            pt[r]   = TAGW'(3 + r);
            pend[r] = 1'b0;
        end
        pack();
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        chk("rst_out", outstanding, 0);
        chk("rst_resp", resp_val, 0);
        chk("rst_err", err_spurious, 0);
        chk("rst_idle", idle, 1);
        chk("rst_mval", mem.mem_req_val, 0);
        rst_n = 1'b1;

        foreach (tv[i]) begin
            req_val              = tv[i].rv;
            mem.mem_req_rdy      = tv[i].rdy;
            mem.mem_resp_val     = tv[i].mrv;
            mem.mem_resp_transid = tv[i].mid;
            mem.mem_resp_data    = {$urandom, $urandom};
            spmv_init            = tv[i].init;
            cycle(1'b1, tv[i]);
        end

        // randomized traffic; requesters hold until accepted
        req_val = '0;
        for (int c = 0; c < 3000; c++) begin
            int bl[$];
            for (int r = 0; r < N; r++) begin
                if (last_hs && last_g == r) pend[r] = 1'b0;
                if (!pend[r] && $urandom_range(1, 0) == 1) begin
                    pend[r] = 1'b1;
                    pa[r]   = {$urandom, $urandom};
                    pt[r]   = TAGW'($urandom);
                end
                req_val[r] = pend[r];
            end
            pack();
            last_hs = 1'b0;
            mem.mem_req_rdy   = ($urandom_range(3, 0) != 0);
            mem.mem_resp_data = {$urandom, $urandom};
            spmv_init         = ($urandom_range(63, 0) == 0);
            for (int i = 0; i < NID; i++) if (m_busy[i]) bl.push_back(i);
            mem.mem_resp_val = 1'b0;
            if (bl.size() > 0 && $urandom_range(1, 0) == 1) begin
                mem.mem_resp_val     = 1'b1;
                mem.mem_resp_transid =
                    TW'(bl[$urandom_range(bl.size() - 1, 0)]);
            end else if ($urandom_range(15, 0) == 0) begin
                mem.mem_resp_val     = 1'b1;
                mem.mem_resp_transid = TW'($urandom);
            end
            cycle(1'b0, dv);
        end

        // async reset with a transaction in flight
        spmv_init        = 1'b0;
        mem.mem_resp_val = 1'b0;
        mem.mem_req_rdy  = 1'b1;
        req_val          = 3'b001;
        cycle(1'b0, dv);
        req_val = '0;
        for (int r = 0; r < N; r++) pend[r] = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        chk("async_out", outstanding, 0);
        chk("async_resp", resp_val, 0);
        model_reset();
        rst_n = 1'b1;
        mem.mem_resp_val     = 1'b1;
        mem.mem_resp_transid = TW'(last_id);
        cycle(1'b0, dv);
        mem.mem_resp_val = 1'b0;
        cycle(1'b0, dv);
        cycle(1'b0, dv);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
